// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and bus-slicing helper for the register file
package regfile_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   // Returns field idx of a flattened bus whose fields are width bits wide (width <= 32).
   function automatic logic [31:0] port_slice(input logic [127:0] bus, input int idx, input int width);
      logic [127:0] w_shifted;
      logic [31:0]  w_mask;
      w_shifted = bus >> (idx * width);
      w_mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
      return w_shifted[31:0] & w_mask;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write, read, issue and scoreboard signals of the register file
interface regfile_sb_if #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int RD_PORTS = 2
);
   localparam int NUM_REGS = 2 ** ADDR_W;

   logic                         reg_write;
   logic [ADDR_W-1:0]            write_reg;
   logic [DATA_W-1:0]            write_data;
   logic [RD_PORTS*ADDR_W-1:0]   read_reg;
   logic [RD_PORTS*DATA_W-1:0]   read_data;
   logic [RD_PORTS-1:0]          read_busy;
   logic                         issue_valid;
   logic [ADDR_W-1:0]            issue_reg;
   logic                         issue_ready;
   logic                         flush;
   logic [NUM_REGS-1:0]          busy_vec;

   modport master (
      output reg_write, write_reg, write_data, read_reg, issue_valid, issue_reg, flush,
      input  read_data, read_busy, issue_ready, busy_vec
   );

   modport slave (
      input  reg_write, write_reg, write_data, read_reg, issue_valid, issue_reg, flush,
      output read_data, read_busy, issue_ready, busy_vec
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits tracking in-flight producers
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_reg_write,
   input  logic [ADDR_W-1:0]       i_write_reg,
   input  logic                    i_issue_valid,
   input  logic [ADDR_W-1:0]       i_issue_reg,
   input  logic                    i_flush,
   output logic                    o_issue_ready,
   output logic [2**ADDR_W-1:0]    o_busy_vec
);
   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_issue_zero;
   logic                w_write_hits_issue;
   logic                w_issue_acc;

   assign w_issue_zero       = (ZERO_REG != 0) && (i_issue_reg == '0);
   assign w_write_hits_issue = i_reg_write && (i_write_reg == i_issue_reg);

   // A retiring write to the same register frees the slot for a back-to-back WAW claim.
   assign o_issue_ready = w_issue_zero | ~r_busy[i_issue_reg] | w_write_hits_issue;
   assign w_issue_acc   = i_issue_valid & o_issue_ready & ~i_flush & ~w_issue_zero;

   // Later assignments take priority: flush, then claim, then write-clear.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_reg_write) begin
         w_busy_nxt[i_write_reg] = 1'b0;
      end
      if (w_issue_acc) begin
         w_busy_nxt[i_issue_reg] = 1'b1;
      end
      if (i_flush) begin
         w_busy_nxt = '0;
      end
      if (ZERO_REG != 0) begin
         w_busy_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and hazard scoreboard
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int RD_PORTS = 2,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input logic          clk,
   input logic          rst_n,
   regfile_sb_if.slave  bus
);
   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] w_busy_vec;
   logic                w_wr_en;

   // Writes to a hardwired zero register are dropped here, which also keeps them out of bypass.
   assign w_wr_en = bus.reg_write && !((ZERO_REG != 0) && (bus.write_reg == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_regs[r] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[bus.write_reg] <= bus.write_data;
      end
   end

   for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
      logic [ADDR_W-1:0] w_idx;
      logic              w_zero;
      logic              w_hit;
      logic [DATA_W-1:0] w_data;

      assign w_idx  = ADDR_W'(port_slice(128'(bus.read_reg), i, ADDR_W));
      assign w_zero = (ZERO_REG != 0) && (w_idx == '0);
      assign w_hit  = (BYPASS != 0) && w_wr_en && (bus.write_reg == w_idx);

      always_comb begin
         w_data = r_regs[w_idx];
         if (w_hit) begin
            w_data = bus.write_data;
         end
         if (w_zero) begin
            w_data = '0;
         end
      end

      assign bus.read_data[i*DATA_W +: DATA_W] = w_data;
      assign bus.read_busy[i]                  = w_busy_vec[w_idx] & ~w_hit & ~w_zero;
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_reg_write   (bus.reg_write),
      .i_write_reg   (bus.write_reg),
      .i_issue_valid (bus.issue_valid),
      .i_issue_reg   (bus.issue_reg),
      .i_flush       (bus.flush),
      .o_issue_ready (bus.issue_ready),
      .o_busy_vec    (w_busy_vec)
   );

   assign bus.busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb in default, zero-reg and no-bypass builds
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int RP = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              reg_write   = 1'b0;
   logic [AW-1:0]     write_reg   = '0;
   logic [DW-1:0]     write_data  = '0;
   logic [RP*AW-1:0]  read_reg    = '0;
   logic              issue_valid = 1'b0;
   logic [AW-1:0]     issue_reg   = '0;
   logic              flush       = 1'b0;

   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) m_if ();
   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) z_if ();
   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) n_if ();

   assign m_if.reg_write = reg_write;   assign z_if.reg_write = reg_write;   assign n_if.reg_write = reg_write;
   assign m_if.write_reg = write_reg;   assign z_if.write_reg = write_reg;   assign n_if.write_reg = write_reg;
   assign m_if.write_data = write_data; assign z_if.write_data = write_data; assign n_if.write_data = write_data;
   assign m_if.read_reg = read_reg;     assign z_if.read_reg = read_reg;     assign n_if.read_reg = read_reg;
   assign m_if.issue_valid = issue_valid; assign z_if.issue_valid = issue_valid; assign n_if.issue_valid = issue_valid;
   assign m_if.issue_reg = issue_reg;   assign z_if.issue_reg = issue_reg;   assign n_if.issue_reg = issue_reg;
   assign m_if.flush = flush;           assign z_if.flush = flush;           assign n_if.flush = flush;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .ZERO_REG(0), .BYPASS(1))
      u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .ZERO_REG(1), .BYPASS(1))
      u_zero (.clk(clk), .rst_n(rst_n), .bus(z_if));
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .ZERO_REG(0), .BYPASS(0))
      u_nobp (.clk(clk), .rst_n(rst_n), .bus(n_if));

   localparam int S_M_RD = 0, S_M_RBUSY = 1, S_M_BVEC = 2, S_M_READY = 3;
   localparam int S_Z_RD = 4, S_Z_RBUSY = 5, S_Z_BVEC = 6, S_Z_READY = 7, S_N_RD = 8;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_M_RD:    return 32'(m_if.read_data);
         S_M_RBUSY: return 32'(m_if.read_busy);
         S_M_BVEC:  return 32'(m_if.busy_vec);
         S_M_READY: return 32'(m_if.issue_ready);
         S_Z_RD:    return 32'(z_if.read_data);
         S_Z_RBUSY: return 32'(z_if.read_busy);
         S_Z_BVEC:  return 32'(z_if.busy_vec);
         S_Z_READY: return 32'(z_if.issue_ready);
         S_N_RD:    return 32'(n_if.read_data);
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic chk(input string name, input int sig, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = exp;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expectations are consumed mid-cycle, once the combinational outputs have settled.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [31:0] a;
         e = q.pop_front();
         a = actual(e.sig);
         checks++;
         if (a !== e.exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", e.name, a, e.exp, $time);
         end
      end
   end

   initial begin
      reg_write = 1'b1; write_reg = 3'd3; write_data = 8'h55;
      read_reg = {3'd3, 3'd0}; issue_valid = 1'b1; issue_reg = 3'd2;
      step();
      chk("rst_hold_rd_nobp", S_N_RD, 32'h0);
      chk("rst_hold_bvec", S_M_BVEC, 32'h0);
      chk("rst_hold_ready", S_M_READY, 32'h1);
      step();
      chk("rst_hold_bvec2", S_M_BVEC, 32'h0);
      step();
      reg_write = 1'b0; issue_valid = 1'b0; rst_n = 1'b1;
      chk("rst_rd", S_M_RD, 32'h0);
      chk("rst_rbusy", S_M_RBUSY, 32'h0);
      chk("rst_bvec", S_M_BVEC, 32'h0);
      chk("rst_ready", S_M_READY, 32'h1);

      step(); reg_write = 1'b1; write_reg = 3'd0; write_data = 8'd42;
      step(); write_reg = 3'd1; write_data = 8'd77;
      step(); write_reg = 3'd3; write_data = 8'd99;
      step(); reg_write = 1'b0; read_reg = {3'd3, 3'd0};
      chk("rd_3_0", S_M_RD, 32'h632A);
      chk("rd_3_0_nobp", S_N_RD, 32'h632A);
      chk("rd_3_0_zero", S_Z_RD, 32'h6300);
      step(); read_reg = {3'd1, 3'd3};
      chk("rd_1_3", S_M_RD, 32'h4D63);

      step(); reg_write = 1'b1; write_reg = 3'd5; write_data = 8'hA5; read_reg = {3'd5, 3'd5};
      chk("bypass_both", S_M_RD, 32'hA5A5);
      chk("bypass_off_old", S_N_RD, 32'h0000);
      chk("bypass_zero_build", S_Z_RD, 32'hA5A5);
      step(); reg_write = 1'b0;
      chk("bypass_off_after", S_N_RD, 32'hA5A5);
      step(); reg_write = 1'b1; write_reg = 3'd0; write_data = 8'd42; read_reg = {3'd0, 3'd0};
      chk("zero_beats_bypass", S_Z_RD, 32'h0000);
      chk("r0_bypass_main", S_M_RD, 32'h2A2A);

      step(); reg_write = 1'b0; issue_valid = 1'b1; issue_reg = 3'd2;
      chk("raw_claim_ready", S_M_READY, 32'h1);
      step(); issue_valid = 1'b0; read_reg = {3'd2, 3'd1};
      chk("raw_bvec", S_M_BVEC, 32'h04);
      chk("raw_rbusy", S_M_RBUSY, 32'h2);
      step(); reg_write = 1'b1; write_reg = 3'd2; write_data = 8'h3C;
      chk("raw_wb_rbusy", S_M_RBUSY, 32'h0);
      chk("raw_wb_rd", S_M_RD, 32'h3C4D);
      chk("raw_wb_bvec_held", S_M_BVEC, 32'h04);
      step(); reg_write = 1'b0;
      chk("raw_cleared_bvec", S_M_BVEC, 32'h0);
      chk("raw_cleared_rbusy", S_M_RBUSY, 32'h0);

      step(); issue_valid = 1'b1; issue_reg = 3'd4;
      step();
      chk("waw_bvec", S_M_BVEC, 32'h10);
      chk("waw_blocked", S_M_READY, 32'h0);
      step(); reg_write = 1'b1; write_reg = 3'd4; write_data = 8'h44;
      chk("waw_retire_ready", S_M_READY, 32'h1);
      step(); reg_write = 1'b0; issue_valid = 1'b0;
      chk("waw_still_busy", S_M_BVEC, 32'h10);
      step(); reg_write = 1'b1; write_reg = 3'd4;
      step(); reg_write = 1'b0;
      chk("waw_cleared", S_M_BVEC, 32'h0);

      step(); issue_valid = 1'b1; issue_reg = 3'd1;
      step(); issue_reg = 3'd6;
      step(); issue_reg = 3'd7;
      step(); issue_valid = 1'b0;
      chk("flush_pre_bvec", S_M_BVEC, 32'hC2);
      step(); flush = 1'b1; issue_valid = 1'b1; issue_reg = 3'd3;
      chk("flush_ready", S_M_READY, 32'h1);
      chk("flush_bvec_held", S_M_BVEC, 32'hC2);
      step(); flush = 1'b0; issue_valid = 1'b0;
      chk("flush_bvec_clr", S_M_BVEC, 32'h0);

      step(); issue_valid = 1'b1; issue_reg = 3'd0;
      step(); read_reg = {3'd0, 3'd0};
      chk("r0_claim_main_ready", S_M_READY, 32'h0);
      chk("r0_claim_zero_ready", S_Z_READY, 32'h1);
      chk("r0_claim_main_bvec", S_M_BVEC, 32'h01);
      chk("r0_claim_zero_bvec", S_Z_BVEC, 32'h00);
      chk("r0_main_rbusy", S_M_RBUSY, 32'h3);
      chk("r0_zero_rbusy", S_Z_RBUSY, 32'h0);
      step(); issue_valid = 1'b0; flush = 1'b1;
      step(); flush = 1'b0;
      chk("r0_flushed", S_M_BVEC, 32'h0);

      step();
      issue_valid = 1'b1; issue_reg = 3'd6; reg_write = 1'b1; write_reg = 3'd3;
      write_data = 8'h77; read_reg = {3'd3, 3'd1};
      #1 rst_n = 1'b0;
      chk("midrst_rd_nobp", S_N_RD, 32'h0);
      chk("midrst_bvec", S_M_BVEC, 32'h0);
      step();
      chk("midrst_rd_nobp2", S_N_RD, 32'h0);
      chk("midrst_bvec2", S_M_BVEC, 32'h0);
      step(); reg_write = 1'b0; issue_valid = 1'b0; rst_n = 1'b1;
      chk("postrst_rd", S_M_RD, 32'h0);
      chk("postrst_bvec", S_M_BVEC, 32'h0);
      step();
      step();

      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file with N read ports and one write port. Optional hardwired zero register and write-to-read bypass. Adds a per-register busy scoreboard that the issue stage uses to detect RAW/WAW hazards. Sits between decode/issue and writeback in the processor datapath and replaces the fixed 8x8, two-read-port register file.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W
RD_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, and is never busy
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
reg_write  in  1  write enable, sampled at posedge clk
write_reg  in  ADDR_W  write index
write_data  in  DATA_W  write data
read_reg  in  RD_PORTS*ADDR_W  read indices; port i = bits [i*ADDR_W +: ADDR_W]
read_data  out  RD_PORTS*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W]
read_busy  out  RD_PORTS  1 = port i register has a pending producer
issue_valid  in  1  issue stage claims issue_reg as a destination
issue_reg  in  ADDR_W  destination index being claimed
issue_ready  out  1  claim is accepted this cycle
flush  in  1  synchronous clear of all busy bits (pipeline flush)
busy_vec  out  NUM_REGS  current scoreboard state, bit r = register r

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset: all registers go to 0 and all busy bits go to 0. Reset asserted mid-operation aborts any write or claim immediately.
- Reset values of outputs: read_data = 0, read_busy = 0, busy_vec = 0, issue_ready = 1.
- Write: at posedge, if reg_write=1, regs[write_reg] <= write_data. Ignored for index 0 when ZERO_REG=1.
- Read: combinational, zero cycles of latency. read_data[i] = regs[read_reg[i]].
- Bypass hit (BYPASS=1): reg_write=1, write_reg==read_reg[i], and the index is not a zero-reg. On a hit, read_data[i] = write_data. Multiple ports may hit at the same time.
- Zero register: with ZERO_REG=1, reads of index 0 always return 0, including when bypass would otherwise apply.
- read_busy[i] = busy[read_reg[i]] & ~bypass_hit[i]. It is always 0 for the zero register.
- Scoreboard next-state per register r, highest priority first:
  1. flush=1 -> busy[r] <= 0 (claims in the same cycle are dropped)
  2. issue accepted for r -> busy[r] <= 1 (a new producer wins over a same-cycle write-clear)
  3. reg_write=1 and write_reg==r -> busy[r] <= 0
  4. otherwise hold
- issue_ready = ~busy[issue_reg] | (reg_write & write_reg==issue_reg). This allows WAW back-to-back with retiring writeback.
- Claims to the zero register: issue_ready=1 and busy is never set.
- An issue is accepted only when issue_valid & issue_ready & ~flush.
- A write to a register that is not busy is legal: data updates and busy stays 0.
- issue_ready and read_busy are combinational; busy_vec is the registered state.

Decomposition:
- Package regfile_pkg holds the default DATA_W/ADDR_W constants and a function to extract a port slice from a flattened bus.
- Sub-module regfile_scoreboard holds the busy-bit array, priority logic, issue_ready and flush. Parameters: ADDR_W, ZERO_REG.
- The storage array, bypass muxes and read ports stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with writes active, release -> all reads 0, busy_vec=0, issue_ready=1. Assert rst_n mid-write -> register reads 0 immediately.
- Write/read: write 42 to r0 and 77 to r1, then 99 to r3. With read_reg={3,0} -> read_data={99,42} (ZERO_REG=0). With ZERO_REG=1, writing 42 to r0 -> r0 reads 0.
- Bypass: with reg_write=1, write_reg=5, write_data=0xA5 and both ports reading r5 -> both read 0xA5 in the same cycle. With BYPASS=0 -> both read the old value until after the edge.
- Scoreboard RAW: claim r2 -> busy_vec[2]=1 and read_busy=1 for a port on r2. Writeback to r2 -> read_busy=0 in that cycle via bypass, and busy_vec[2]=0 the next cycle.
- WAW/simultaneous: with r4 busy, issue_valid on r4 -> issue_ready=0. Same cycle with reg_write to r4 -> issue_ready=1, and busy_vec[4] stays 1 after the edge.
- Flush: claim r1, r6, r7, then flush=1 together with issue_valid on r3 -> busy_vec=0 next cycle and r3 is not claimed.
